// File: rtl/accelerator_standard_fnn_h_collector_pkg.sv
// Shared types and constants for the standard FNN accelerator H collector.
// Optional feature macro: ACCELERATOR_STANDARD_FNN_H_COLLECTOR_RELU_EN
package accelerator_standard_fnn_pkg;

    localparam int DATA_SIZE    = 64;  // width of one H element (two's complement)
    localparam int CONTROL_SIZE = 64;  // width of control/size words
    localparam int L            = 64;  // buffer depth = max H vector length
    localparam int PTR_W        = (L > 1) ? $clog2(L) : 1;

    typedef logic [DATA_SIZE-1:0] data_t;
    typedef logic [PTR_W-1:0]     ptr_t;

    localparam data_t ZERO_DATA = '0;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } state_t;

endpackage

// File: rtl/accelerator_standard_fnn_h_collector_if.sv
// Handshake/data bundle between the FNN, the H collector and the downstream consumer.
// master = the side driving START/H_IN/H_OUT_READY, slave = the collector.
interface accelerator_standard_fnn_h_collector_if;
    import accelerator_standard_fnn_pkg::*;

    logic  start;
    logic  ready;
    data_t size_l_in;
    logic  h_in_enable;
    data_t h_in;
    logic  h_out_valid;
    logic  h_out_ready;
    data_t h_out;
    logic  h_out_last;
    logic  size_error;

    modport master (
        output start, size_l_in, h_in_enable, h_in, h_out_ready,
        input  ready, h_out_valid, h_out, h_out_last, size_error
    );

    modport slave (
        input  start, size_l_in, h_in_enable, h_in, h_out_ready,
        output ready, h_out_valid, h_out, h_out_last, size_error
    );

endinterface

// File: rtl/accelerator_standard_fnn_h_buffer.sv
// L x DATA_SIZE register file: one write port, one registered read port.
// A read of the address written in the same cycle returns the new data.
module accelerator_standard_fnn_h_buffer
    import accelerator_standard_fnn_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  wr_en,
    input  ptr_t  wr_addr,
    input  data_t wr_data,
    input  logic  rd_en,
    input  ptr_t  rd_addr,
    output data_t rd_data
);

    data_t mem [L];

    // Storage array write port.
    // NOTE: the array has no reset; its contents are don't-care until written, and leaving it unreset keeps it mappable to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port with same-cycle write forwarding (needed for len==1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= ZERO_DATA;
        end else if (rd_en) begin
            rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
        end
    end

endmodule

// File: rtl/accelerator_standard_fnn_h_collector.sv
// H collector: captures the FNN's strobed H vector into a buffer, then replays it
// over a valid/ready stream. Holds the FSM, pointers, length latch and handshake.
// Optional feature macro: ACCELERATOR_STANDARD_FNN_H_COLLECTOR_RELU_EN
//   (defined: negative elements are stored as zero on capture).
module accelerator_standard_fnn_h_collector
    import accelerator_standard_fnn_pkg::*;
(
    input logic clk,
    input logic rst,
    accelerator_standard_fnn_h_collector_if.slave bus
);

    state_t state_q, state_d;
    ptr_t   wr_ptr_q, rd_ptr_q, last_idx_q;
    logic   ready_q, size_error_q;

    logic   start_ok, size_zero, size_over;
    logic   wr_en, wr_last, rd_en, xfer, xfer_last;
    ptr_t   rd_addr;
    data_t  wr_data, rd_data;

    // A START during the READY pulse belongs to the DRAIN->IDLE cycle and is ignored.
    assign size_zero = (bus.size_l_in == ZERO_DATA);
    assign size_over = (bus.size_l_in > DATA_SIZE'(L));
    assign start_ok  = (state_q == IDLE) && bus.start && !ready_q;
    assign wr_last   = wr_en && (wr_ptr_q == last_idx_q);
    assign xfer      = (state_q == DRAIN) && bus.h_out_ready;
    assign xfer_last = xfer && (rd_ptr_q == last_idx_q);

`ifdef ACCELERATOR_STANDARD_FNN_H_COLLECTOR_RELU_EN
    assign wr_data = bus.h_in[DATA_SIZE-1] ? ZERO_DATA : bus.h_in;
`else
    assign wr_data = bus.h_in;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and buffer port strobes.
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = rd_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok && !size_zero) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                wr_en = bus.h_in_enable;
                if (bus.h_in_enable && (wr_ptr_q == last_idx_q)) begin
                    state_d = DRAIN;
                    rd_en   = 1'b1;
                    rd_addr = '0;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (rd_ptr_q == last_idx_q) begin
                        state_d = IDLE;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = rd_ptr_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Length latch, pointers, READY pulse and sticky size error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_idx_q   <= '0;
            ready_q      <= 1'b0;
            size_error_q <= 1'b0;
        end else begin
            ready_q <= (start_ok && size_zero) || xfer_last;
            if (start_ok && size_over) begin
                size_error_q <= 1'b1;
            end
            if (start_ok && !size_zero) begin
                last_idx_q <= size_over ? ptr_t'(L - 1)
                                        : bus.size_l_in[PTR_W-1:0] - PTR_W'(1);
                wr_ptr_q   <= '0;
            end else if (wr_en) begin
                wr_ptr_q <= wr_last ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (wr_last) begin
                rd_ptr_q <= '0;
            end else if (xfer) begin
                rd_ptr_q <= xfer_last ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    accelerator_standard_fnn_h_buffer u_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.h_out_valid = (state_q == DRAIN);
    assign bus.h_out       = rd_data;
    assign bus.h_out_last  = (state_q == DRAIN) && (rd_ptr_q == last_idx_q);
    assign bus.ready       = ready_q;
    assign bus.size_error  = size_error_q;

endmodule

// File: tb/tb_accelerator_standard_fnn_h_collector.sv
// Self-checking bench for the H collector: randomized vectors, gaps and stalls
// checked against a queue-based reference model of the capture/replay behaviour.
module tb_accelerator_standard_fnn_h_collector;
    import accelerator_standard_fnn_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accelerator_standard_fnn_h_collector_if bus ();

    accelerator_standard_fnn_h_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    tests_run = 0;
    int    failed    = 0;
    logic  err_exp   = 1'b0;
    data_t stim_q[$];

    // Reference for what the buffer should hold for an input element.
    function automatic data_t model_store(input data_t x);
`ifdef ACCELERATOR_STANDARD_FNN_H_COLLECTOR_RELU_EN
        return x[DATA_SIZE-1] ? data_t'(0) : x;
`else
        return x;
`endif
    endfunction

    function automatic data_t rand_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic fill_random(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(rand_data());
    endtask

    // Start a collection of 'size', strobe every element in stim_q, then drain
    // with optional random/forced stalls and compare each element to the model.
    task automatic run_vector(input data_t size, input int gap_pct, input int stall_pct,
                              input int stall_at, input int stall_len, input bit start_on_ready);
        int    n;
        int    idx;
        int    budget;
        int    stall_cnt;
        int    gaps;
        logic  rdy;
        data_t exp_q[$];
        n = (size > data_t'(L)) ? L : int'(size[31:0]);

        @(negedge clk);
        bus.start     = 1'b1;
        bus.size_l_in = size;
        @(negedge clk);
        bus.start = 1'b0;
        if (size > data_t'(L)) err_exp = 1'b1;
        tests_run++;
        if (bus.size_error !== err_exp) begin
            failed++;
            $display("FAIL size_error_after_start: got %b expected %b", bus.size_error, err_exp);
        end

        if (n == 0) begin
            tests_run++;
            if ({bus.ready, bus.h_out_valid} !== 2'b10) begin
                failed++;
                $display("FAIL zero_len_ready_pulse: got ready=%b valid=%b expected ready=1 valid=0",
                         bus.ready, bus.h_out_valid);
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                tests_run++;
                if ({bus.ready, bus.h_out_valid} !== 2'b00) begin
                    failed++;
                    $display("FAIL zero_len_quiet: got ready=%b valid=%b expected 0 0",
                             bus.ready, bus.h_out_valid);
                end
            end
            return;
        end

        for (int i = 0; i < stim_q.size(); i++) begin
            gaps = 0;
            while (gaps < 3 && $urandom_range(99) < gap_pct) begin
                @(negedge clk);
                gaps++;
            end
            bus.h_in_enable = 1'b1;
            bus.h_in        = stim_q[i];
            if (i < n) exp_q.push_back(model_store(stim_q[i]));
            @(negedge clk);
            bus.h_in_enable = 1'b0;
            if (i < n) begin
                tests_run++;
                if (bus.h_out_valid !== (i == n - 1)) begin
                    failed++;
                    $display("FAIL capture_valid[%0d]: got %b expected %b", i, bus.h_out_valid, i == n - 1);
                end
            end
        end

        idx       = 0;
        budget    = 0;
        stall_cnt = 0;
        while (idx < n && budget < 50 * n + 100) begin
            tests_run++;
            if (bus.h_out_valid !== 1'b1 || bus.ready !== 1'b0) begin
                failed++;
                $display("FAIL drain_valid[%0d]: got valid=%b ready=%b expected 1 0",
                         idx, bus.h_out_valid, bus.ready);
            end
            tests_run++;
            if (bus.h_out !== exp_q[idx] || bus.h_out_last !== (idx == n - 1)) begin
                failed++;
                $display("FAIL drain_data[%0d]: got %h last=%b expected %h last=%b",
                         idx, bus.h_out, bus.h_out_last, exp_q[idx], idx == n - 1);
            end
            if (idx == stall_at && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end else begin
                rdy = ($urandom_range(99) >= stall_pct);
            end
            bus.h_out_ready = rdy;
            if (rdy) idx++;
            @(negedge clk);
            budget++;
        end
        bus.h_out_ready = 1'b0;
        if (idx < n) begin
            tests_run++;
            failed++;
            $display("FAIL drain_timeout: got %0d elements expected %0d", idx, n);
        end

        tests_run++;
        if ({bus.ready, bus.h_out_valid, bus.h_out_last} !== 3'b100) begin
            failed++;
            $display("FAIL end_ready_pulse: got ready=%b valid=%b last=%b expected 1 0 0",
                     bus.ready, bus.h_out_valid, bus.h_out_last);
        end
        tests_run++;
        if (bus.size_error !== err_exp) begin
            failed++;
            $display("FAIL size_error_end: got %b expected %b", bus.size_error, err_exp);
        end
        if (start_on_ready) begin
            bus.start     = 1'b1;
            bus.size_l_in = data_t'(2);
        end
        @(negedge clk);
        bus.start = 1'b0;
        tests_run++;
        if (bus.ready !== 1'b0) begin
            failed++;
            $display("FAIL ready_single_cycle: got %b expected 0", bus.ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.h_out_valid, bus.ready, bus.h_out_last, bus.size_error} !== 4'b0 ||
            bus.h_out !== data_t'(0)) begin
            failed++;
            $display("FAIL reset_outputs: got v=%b r=%b l=%b e=%b d=%h expected all 0",
                     bus.h_out_valid, bus.ready, bus.h_out_last, bus.size_error, bus.h_out);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.h_out_valid, bus.ready, bus.h_out_last, bus.size_error} !== 4'b0) begin
            failed++;
            $display("FAIL post_reset_idle: got v=%b r=%b l=%b e=%b expected all 0",
                     bus.h_out_valid, bus.ready, bus.h_out_last, bus.size_error);
        end
    endtask

    task automatic test_basic();
        stim_q = '{data_t'(1), data_t'(2), data_t'(3), data_t'(4)};
        run_vector(data_t'(4), 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_stall();
        stim_q = '{data_t'(1), data_t'(2), data_t'(3), data_t'(4)};
        run_vector(data_t'(4), 0, 0, 1, 3, 1'b0);
    endtask

    task automatic test_zero_len();
        stim_q.delete();
        run_vector(data_t'(0), 0, 0, -1, 0, 1'b0);
        fill_random(3);
        run_vector(data_t'(3), 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_negative_element();
        stim_q = '{-data_t'(7)};
        run_vector(data_t'(1), 0, 0, -1, 0, 1'b0);
        stim_q = '{data_t'(5), -data_t'(7), {1'b1, {(DATA_SIZE-1){1'b0}}}};
        run_vector(data_t'(3), 30, 30, -1, 0, 1'b0);
    endtask

    task automatic test_start_during_ready();
        fill_random(2);
        run_vector(data_t'(2), 0, 0, -1, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            bus.h_in_enable = 1'b1;
            bus.h_in        = rand_data();
            @(negedge clk);
            tests_run++;
            if (bus.h_out_valid !== 1'b0) begin
                failed++;
                $display("FAIL start_ignored_on_ready[%0d]: got valid=%b expected 0", i, bus.h_out_valid);
            end
        end
        bus.h_in_enable = 1'b0;
        fill_random(3);
        run_vector(data_t'(3), 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_oversize();
        fill_random(L + 5);
        run_vector(data_t'(L + 5), 10, 20, -1, 0, 1'b0);
        fill_random(3);
        run_vector(data_t'(3), 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        @(negedge clk);
        bus.start     = 1'b1;
        bus.size_l_in = data_t'(4);
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.h_in_enable = 1'b1;
            bus.h_in        = data_t'(10 + i);
            @(negedge clk);
        end
        bus.h_in_enable = 1'b0;
        bus.h_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.h_out_ready = 1'b0;
        tests_run++;
        if (bus.h_out_valid !== 1'b1 || bus.h_out !== model_store(data_t'(12))) begin
            failed++;
            $display("FAIL pre_reset_third: got valid=%b data=%h expected 1 %h",
                     bus.h_out_valid, bus.h_out, model_store(data_t'(12)));
        end
        rst = 1'b1;
        err_exp = 1'b0;
        #1;
        tests_run++;
        if ({bus.h_out_valid, bus.ready, bus.h_out_last, bus.size_error} !== 4'b0 ||
            bus.h_out !== data_t'(0)) begin
            failed++;
            $display("FAIL async_reset_mid_drain: got v=%b r=%b l=%b e=%b d=%h expected all 0",
                     bus.h_out_valid, bus.ready, bus.h_out_last, bus.size_error, bus.h_out);
        end
        @(negedge clk);
        rst = 1'b0;
        fill_random(2);
        run_vector(data_t'(2), 0, 0, -1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            fill_random($urandom_range(L, 1));
            run_vector(data_t'(stim_q.size()), 25, 30, -1, 0, 1'b0);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.size_l_in   = '0;
        bus.h_in_enable = 1'b0;
        bus.h_in        = '0;
        bus.h_out_ready = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_negative_element();
        test_start_during_ready();
        test_oversize();
        test_reset_mid_drain();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
